lsab_gather: RTL

- Four-channel LSAB read-side aggregator, the counterpart to the column-write LSAB. The write LSAB fans one input bus out to four FIFOs; this block does the reverse.
- Four independent producers each push 32-bit words into a private FIFO.
- A single consumer drains any FIFO through one shared read port, selected per cycle by READ_FIFO.
- Sits between the hyperfabric receive lanes and the MCU/cache side. It reports per-channel EMPTY, STOP (low-water) and BFULL (high-water) status.

---
 rtl/lsab_pkg.sv | 14 +
 rtl/lsab_gather_fifo.sv | 78 +++++++
 rtl/lsab_gather.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lsab_pkg.sv
// Shared types and defaults for the LSAB read-side gather block.
// Data width, channel count and FIFO threshold defaults.
package lsab_pkg;

  localparam int LSAB_DATA_W = 32;
  localparam int LSAB_NCHAN  = 4;

  localparam int DEF_DEPTH_LOG2   = 7;
  localparam int DEF_BFULL_MARGIN = 4;
  localparam int DEF_STOP_THRESH  = 2;

  typedef logic [1:0] chan_t;

endpackage

// File: rtl/lsab_gather_fifo.sv
// One LSAB gather channel: RAM, pointers, fill count and status flags.
// The read word is captured on the pop edge, before any same-edge write lands.
module lsab_gather_fifo
  import lsab_pkg::*;
#(
  parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
  parameter int BFULL_MARGIN = DEF_BFULL_MARGIN,
  parameter int STOP_THRESH  = DEF_STOP_THRESH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [LSAB_DATA_W-1:0] push_data,
  input  logic                   pop,
  output logic                   push_ok,
  output logic                   pop_ok,
  output logic [LSAB_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   stop,
  output logic                   bfull
);

  localparam int AW      = DEPTH_LOG2;
  localparam int DEPTH_I = 1 << AW;
  localparam int BF_I    = DEPTH_I - BFULL_MARGIN;

  localparam logic [AW:0]   DEPTH_F = DEPTH_I[AW:0];
  localparam logic [AW:0]   BF_LVL  = BF_I[AW:0];
  localparam logic [AW:0]   ST_LVL  = STOP_THRESH[AW:0];
  localparam logic [AW:0]   F_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] P_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [LSAB_DATA_W-1:0] mem [DEPTH_I];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            fill;
  logic [AW:0]            fill_nxt;

  // A pop on a full FIFO frees the slot the same-edge push needs.
  assign pop_ok  = pop && (fill != '0);
  assign push_ok = push && ((fill != DEPTH_F) || pop_ok);

  always_comb begin
    fill_nxt = fill;
    unique case ({push_ok, pop_ok})
      2'b10:   fill_nxt = fill + F_ONE;
      2'b01:   fill_nxt = fill - F_ONE;
      default: fill_nxt = fill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      rd_data <= '0;
      empty   <= 1'b1;
      stop    <= 1'b1;
      bfull   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + P_ONE;
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + P_ONE;
        rd_data <= mem[rd_ptr];
      end
      fill  <= fill_nxt;
      empty <= (fill_nxt == '0);
      stop  <= (fill_nxt <= ST_LVL);
      bfull <= (fill_nxt >= BF_LVL);
    end
  end

endmodule

// File: rtl/lsab_gather.sv
// Four-channel LSAB gather: per-channel FIFOs drained through one read port.
// Two-stage tagged read pipeline plus sticky overrun/underrun vectors.
module lsab_gather
  import lsab_pkg::*;
#(
  parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
  parameter int BFULL_MARGIN = DEF_BFULL_MARGIN,
  parameter int STOP_THRESH  = DEF_STOP_THRESH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [LSAB_DATA_W-1:0] IN_0,
  input  logic [LSAB_DATA_W-1:0] IN_1,
  input  logic [LSAB_DATA_W-1:0] IN_2,
  input  logic [LSAB_DATA_W-1:0] IN_3,
  input  logic                   WRITE_0,
  input  logic                   WRITE_1,
  input  logic                   WRITE_2,
  input  logic                   WRITE_3,
  input  logic                   READ,
  input  logic [1:0]             READ_FIFO,
  output logic [LSAB_DATA_W-1:0] OUT,
  output logic                   OUT_VALID,
  output logic                   EMPTY_0,
  output logic                   EMPTY_1,
  output logic                   EMPTY_2,
  output logic                   EMPTY_3,
  output logic                   STOP_0,
  output logic                   STOP_1,
  output logic                   STOP_2,
  output logic                   STOP_3,
  output logic                   BFULL_0,
  output logic                   BFULL_1,
  output logic                   BFULL_2,
  output logic                   BFULL_3,
  output logic [3:0]             OVERRUN,
  output logic [3:0]             UNDERRUN
);

  logic [LSAB_DATA_W-1:0] wdata [LSAB_NCHAN];
  logic [LSAB_DATA_W-1:0] rdata [LSAB_NCHAN];
  logic [LSAB_NCHAN-1:0]  wr;
  logic [LSAB_NCHAN-1:0]  rd;
  logic [LSAB_NCHAN-1:0]  push_ok;
  logic [LSAB_NCHAN-1:0]  pop_ok;
  logic [LSAB_NCHAN-1:0]  empty;
  logic [LSAB_NCHAN-1:0]  stop;
  logic [LSAB_NCHAN-1:0]  bfull;

  logic                   s0_valid;
  chan_t                  s0_tag;
  logic                   s1_valid;
  logic [LSAB_DATA_W-1:0] s1_data;

  assign wdata[0] = IN_0;
  assign wdata[1] = IN_1;
  assign wdata[2] = IN_2;
  assign wdata[3] = IN_3;
  assign wr = {WRITE_3, WRITE_2, WRITE_1, WRITE_0};

  always_comb begin
    rd = '0;
    if (READ) rd[READ_FIFO] = 1'b1;
  end

  for (genvar i = 0; i < LSAB_NCHAN; i++) begin : g_ch
    lsab_gather_fifo #(
      .DEPTH_LOG2  (DEPTH_LOG2),
      .BFULL_MARGIN(BFULL_MARGIN),
      .STOP_THRESH (STOP_THRESH)
    ) u_fifo (
      .clk      (CLK),
      .rst      (RST),
      .push     (wr[i]),
      .push_data(wdata[i]),
      .pop      (rd[i]),
      .push_ok  (push_ok[i]),
      .pop_ok   (pop_ok[i]),
      .rd_data  (rdata[i]),
      .empty    (empty[i]),
      .stop     (stop[i]),
      .bfull    (bfull[i])
    );
  end

  // Stage 0 tags the pop, stage 1 picks the channel word, OUT presents it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0_valid  <= 1'b0;
      s0_tag    <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      OVERRUN   <= '0;
      UNDERRUN  <= '0;
    end else begin
      s0_valid  <= |pop_ok;
      s0_tag    <= READ_FIFO;
      s1_valid  <= s0_valid;
      s1_data   <= rdata[s0_tag];
      OUT_VALID <= s1_valid;
      if (s1_valid) OUT <= s1_data;
      OVERRUN   <= OVERRUN | (wr & ~push_ok);
      UNDERRUN  <= UNDERRUN | (rd & ~pop_ok);
    end
  end

  assign EMPTY_0 = empty[0];
  assign EMPTY_1 = empty[1];
  assign EMPTY_2 = empty[2];
  assign EMPTY_3 = empty[3];
  assign STOP_0  = stop[0];
  assign STOP_1  = stop[1];
  assign STOP_2  = stop[2];
  assign STOP_3  = stop[3];
  assign BFULL_0 = bfull[0];
  assign BFULL_1 = bfull[1];
  assign BFULL_2 = bfull[2];
  assign BFULL_3 = bfull[3];

endmodule
